// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Define PS2_TX_RETRY_EN to re-send the byte up to MAX_RETRY extra times after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 32,
  parameter int TIMEOUT_CYCLES = 3840,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk256,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  inout  wire        PS2C,
  inout  wire        PS2D,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t      state;
  logic [1:0]  c_s, d_s;
  logic        c_q, c_oe, d_oe, fall, tmo_hit, fail_now, retry;
  logic [7:0]  data_q;
  logic [9:0]  shreg;
  logic [3:0]  bitcnt;
  logic [11:0] cnt;
  assign PS2C       = c_oe ? 1'b0 : 1'bz;
  assign PS2D       = d_oe ? 1'b0 : 1'bz;
  assign rx_inhibit = tx_busy;
  assign fall       = c_q & ~c_s[1];
  assign tmo_hit    = (state == SHIFT || state == ACK || state == WAIT_IDLE) && cnt == 12'(TIMEOUT_CYCLES - 1);
  assign fail_now   = tmo_hit || (state == ACK && fall && d_s[1]);
`ifdef PS2_TX_RETRY_EN
  logic [7:0] retries;
  assign retry = retries < 8'(MAX_RETRY);
  always_ff @(posedge clk256 or posedge reset)
    if (reset) retries <= '0;
    else if (state == IDLE) retries <= '0;
    else if (fail_now && retry) retries <= retries + 8'd1;
`else
  logic unused;
  assign unused = |MAX_RETRY;
  assign retry  = 1'b0;
`endif
  // One counter serves both the inhibit interval and the post-release timeout.
  always_ff @(posedge clk256 or posedge reset)
    if (reset) begin
      state    <= IDLE;
      c_s      <= 2'b11;
      d_s      <= 2'b11;
      c_q      <= 1'b1;
      c_oe     <= 1'b0;
      d_oe     <= 1'b0;
      data_q   <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      cnt      <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      c_s      <= {c_s[0], PS2C};
      d_s      <= {d_s[0], PS2D};
      c_q      <= c_s[1];
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (fail_now) begin
        d_oe  <= 1'b0;
        c_oe  <= retry;
        cnt   <= '0;
        shreg <= {1'b1, ~^data_q, data_q};
        state <= retry ? INHIBIT : IDLE;
        if (!retry) begin
          tx_error <= 1'b1;
          tx_busy  <= 1'b0;
        end
      end else case (state)
        IDLE: if (tx_start) begin
          data_q  <= tx_data;
          shreg   <= {1'b1, ~^tx_data, tx_data};
          c_oe    <= 1'b1;
          cnt     <= '0;
          tx_busy <= 1'b1;
          state   <= INHIBIT;
        end
        INHIBIT: if (cnt == 12'(INHIBIT_CYCLES - 1)) begin
          d_oe  <= 1'b1;
          state <= REQ;
        end else cnt <= cnt + 12'd1;
        REQ: begin
          c_oe   <= 1'b0;
          cnt    <= '0;
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 12'd1;
          if (fall) begin
            d_oe   <= ~shreg[0];
            shreg  <= {1'b0, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd9) state <= ACK;
          end
        end
        ACK: begin
          cnt <= cnt + 12'd1;
          if (fall) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          cnt <= cnt + 12'd1;
          if (c_s[1] && d_s[1]) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model clocking and (N)ACKing host frames.
module tb_ps2_host_tx;
  logic       clk256 = 1'b0, reset = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_busy, tx_done, tx_error, rx_inhibit;
  logic       dev_c = 1'b0, dev_d = 1'b0, both = 1'b0;
  wire        ps2c, ps2d;
  int         tests = 0, fails = 0, n_done = 0, n_err = 0, phases = 0, lowrun = 0;
  int         d0, e0, inh, req, t;
  logic [10:0] fr;
  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c ? 1'b0 : 1'bz;
  assign ps2d = dev_d ? 1'b0 : 1'bz;
  ps2_host_tx dut (.clk256(clk256), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .PS2C(ps2c), .PS2D(ps2d), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .rx_inhibit(rx_inhibit));
  always #5 clk256 = ~clk256;
  always @(negedge clk256) begin
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) n_err <= n_err + 1;
    if (tx_done && tx_error) both <= 1'b1;
    lowrun <= (ps2c === 1'b0) ? lowrun + 1 : 0;
    if (ps2c === 1'b0 && lowrun == 20) phases <= phases + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Pulse tx_start, then measure the inhibit-only and request intervals on the bus.
  task automatic start_tx(input logic [7:0] b, output int n_inh, output int n_req);
    @(negedge clk256);
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clk256);
    tx_start = 1'b0;
    n_inh = 0;
    n_req = 0;
    while (ps2c === 1'b0 && ps2d === 1'b1 && n_inh < 100) begin n_inh++; @(negedge clk256); end
    while (ps2c === 1'b0 && ps2d === 1'b0 && n_req < 10) begin n_req++; @(negedge clk256); end
  endtask
  task automatic wait_release();
    int w = 0;
    while (ps2c !== 1'b0 && w < 500) begin @(negedge clk256); w++; end
    while (ps2c !== 1'b1 && w < 500) begin @(negedge clk256); w++; end
    check("release", w < 500, 1);
  endtask
  // Device: nclk clock pulses, sampling PS2D while PS2C is low; pulse 11 carries the ACK.
  task automatic device(input int nclk, input logic ack, output logic [10:0] bits);
    bits = '0;
    repeat (4) @(negedge clk256);
    bits[0] = ps2d;
    for (int k = 1; k <= nclk && k <= 10; k++) begin
      dev_c = 1'b1;
      repeat (8) @(negedge clk256);
      bits[k] = ps2d;
      dev_c = 1'b0;
      repeat (8) @(negedge clk256);
    end
    if (nclk == 11) begin
      dev_d = ack;
      repeat (4) @(negedge clk256);
      dev_c = 1'b1;
      repeat (8) @(negedge clk256);
      dev_c = 1'b0;
      repeat (4) @(negedge clk256);
      dev_d = 1'b0;
      repeat (6) @(negedge clk256);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk256);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    check("rst_ps2c", ps2c, 1);
    check("rst_ps2d", ps2d, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk256);
    // 1: ED with ACK
    d0 = n_done; e0 = n_err;
    start_tx(8'hED, inh, req);
    check("t1_inhibit", inh, 32);
    check("t1_req", req, 1);
    check("t1_busy", tx_busy, 1);
    check("t1_rx_inhibit", rx_inhibit, 1);
    device(11, 1'b1, fr);
    check("t1_frame", fr, 11'h7DA);
    check("t1_done", n_done - d0, 1);
    check("t1_error", n_err - e0, 0);
    check("t1_busy_end", tx_busy, 0);
`ifdef PS2_TX_RETRY_EN
    // 6: two NACKs then ACK
    d0 = n_done; e0 = n_err;
    t = phases;
    start_tx(8'hED, inh, req);
    device(11, 1'b0, fr);
    check("t6_busy1", tx_busy, 1);
    wait_release();
    device(11, 1'b0, fr);
    check("t6_busy2", tx_busy, 1);
    check("t6_frame2", fr, 11'h7DA);
    wait_release();
    device(11, 1'b1, fr);
    check("t6_phases", phases - t, 3);
    check("t6_done", n_done - d0, 1);
    check("t6_error", n_err - e0, 0);
`else
    // 2: 00 with NACK
    d0 = n_done; e0 = n_err;
    start_tx(8'h00, inh, req);
    device(11, 1'b0, fr);
    check("t2_frame", fr, 11'h600);
    check("t2_error", n_err - e0, 1);
    check("t2_done", n_done - d0, 0);
    check("t2_ps2c", ps2c, 1);
    check("t2_ps2d", ps2d, 1);
    check("t2_busy", tx_busy, 0);
    // 3: device silent after release
    e0 = n_err;
    start_tx(8'hED, inh, req);
    t = 0;
    while (tx_error !== 1'b1 && t < 5000) begin @(negedge clk256); t++; end
    check("t3_timeout_cycles", t, 3840);
    check("t3_ps2c", ps2c, 1);
    check("t3_ps2d", ps2d, 1);
    check("t3_busy", tx_busy, 0);
    @(negedge clk256);
    check("t3_error_once", n_err - e0, 1);
`endif
    // 4: second tx_start during a transfer is ignored
    d0 = n_done; e0 = n_err;
    start_tx(8'hF4, inh, req);
    tx_data = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk256);
    tx_start = 1'b0;
    device(11, 1'b1, fr);
    check("t4_frame", fr, 11'h5E8);
    check("t4_done", n_done - d0, 1);
    check("t4_error", n_err - e0, 0);
    repeat (20) @(negedge clk256);
    check("t4_idle", tx_busy, 0);
    // 5: async reset after four device clocks
    start_tx(8'h00, inh, req);
    device(4, 1'b1, fr);
    check("t5_pre_ps2d", ps2d, 0);
    check("t5_pre_busy", tx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_ps2c", ps2c, 1);
    check("t5_ps2d", ps2d, 1);
    check("t5_busy", tx_busy, 0);
    @(negedge clk256);
    reset = 1'b0;
    repeat (2) @(negedge clk256);
    d0 = n_done; e0 = n_err;
    start_tx(8'hED, inh, req);
    check("t5_inhibit", inh, 32);
    device(11, 1'b1, fr);
    check("t5_frame", fr, 11'h7DA);
    check("t5_done", n_done - d0, 1);
    check("t5_error", n_err - e0, 0);
    check("done_err_excl", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
